uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
//
// PURPOSE
// - Receive buffer directly downstream of the UART receiver. Consumes its 16-bit
//   word (bit15=0 means byte valid in [7:0]; 0x8000 means no data).
// - Queues received bytes in a show-ahead FIFO so the CPU can poll slower than the line rate.
// - Presents the head byte on a memory-mapped 16-bit word in the same encoding as the receiver.
// - The CPU pops the head by writing the register (load pulse).
//
// PARAMETERS
// - DEPTH   16  FIFO entries; must be a power of two, >= 2
// - ADDR_W  4   log2(DEPTH); pointer width, count is ADDR_W+1 bits
//
// PORTS
// - clk       in   1   system clock, all logic on posedge
// - reset     in   1   synchronous, active-high
// - rx_word   in   16  receiver output: bit15=0 -> byte valid in [7:0]
// - load      in   1   CPU write strobe to this register; pops head (data ignored)
// - out       out  16  empty: 16'h8000; else {8'h00, head byte}
// - full      out  1   count == DEPTH
// - overflow  out  1   sticky: a byte was dropped because FIFO was full
//
// BEHAVIOUR
// - Reset: rd_ptr=wr_ptr=0, count=0, overflow=0, rx_prev=1.
//   Outputs after reset: out=16'h8000, full=0. Mid-operation reset discards all queued bytes.
// - Valid detect: rx_prev is a registered copy of rx_word[15].
//   push_req = !rx_word[15] && rx_prev (falling-edge qualified).
//   A receiver valid held >1 cycle yields exactly one push.
// - pop_req = load && count!=0. load while empty has no effect.
// - Push: mem[wr_ptr] <= rx_word[7:0]; wr_ptr+1 mod DEPTH.
// - Pop: rd_ptr+1 mod DEPTH. Pointers wrap naturally at ADDR_W bits.
// - Count update:
//   - push only: +1
//   - pop only: -1
//   - both: unchanged, both pointers advance
// - Full: push_req && count==DEPTH && !pop_req -> byte dropped, overflow<=1.
//   Simultaneous pop+push when full is accepted; count stays DEPTH.
// - Empty with push_req and load in same cycle: pop ignored, byte stored, count=1.
// - Latency: byte valid on rx_word in cycle N -> visible on out in cycle N+1.
//   After a load in cycle N, out shows the next byte (or 0x8000) in cycle N+1.
// - out is combinational from count and mem[rd_ptr]; no state machine beyond pointers/count.
// - overflow clears only on reset.
//
// CONFIGURATION
// - UART_RX_FIFO_STATUS_EN defined:
//   - out[14] = overflow.
//   - When non-empty, out[13:8] = count saturated to 63.
//   - Empty word = {1'b1, overflow, 14'b0}.
// - UART_RX_FIFO_STATUS_EN undefined: out[14:8] always 0; overflow still driven on its port.
//
// TESTING
// - Reset then idle (rx_word=0x8000) -> out=0x8000, full=0, overflow=0.
// - rx_word=0x0041 for 1 cycle -> next cycle out=0x0041.
//   Pulse load -> next cycle out=0x8000.
// - rx_word=0x0055 held 5 cycles -> exactly one entry.
//   Second load leaves out=0x8000 with no underflow.
// - Push 0x01..0x10 (16 bytes) -> full=1.
//   Push 0x11 -> overflow=1, dropped.
//   16 loads return 0x01..0x10 in order, then 0x8000.
// - Full FIFO, push 0x22 with load in same cycle -> count stays 16, full=1, overflow=0.
//   0x22 is read last.
// - Push 3 bytes, assert reset mid-stream -> out=0x8000.
//   Next push 0x7E reads back as 0x007E (pointers wrapped/cleared correctly).

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO behind the UART receiver, presenting the head byte as a polled 16-bit word.
// Optional status fields in the output word are enabled by defining UART_RX_FIFO_STATUS_EN.
module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] rx_word,
  input  logic        load,
  output logic [15:0] out,
  output logic        full,
  output logic        overflow
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   count;
  logic              rx_prev;

  logic push_req;
  logic pop_req;
  logic push_ok;
  logic drop;

  // A receiver valid lasting several cycles must be stored once, so only its leading edge pushes.
  assign push_req = !rx_word[15] && rx_prev;
  assign pop_req  = load && (count != '0);
  assign full     = (count == FULL_COUNT);
  assign push_ok  = push_req && (!full || pop_req);
  assign drop     = push_req && full && !pop_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      rx_prev  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments keep every register update based on pre-edge values.
      rx_prev <= rx_word[15];
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_req) rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_req)      count <= count + 1'b1;
      else if (pop_req && !push_ok) count <= count - 1'b1;
      if (drop) overflow <= 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) mem[wr_ptr] <= rx_word[7:0];
  end

`ifdef UART_RX_FIFO_STATUS_EN
  logic [5:0] count_sat;

  if (ADDR_W + 1 <= 6) begin : g_sat_narrow
    assign count_sat = 6'(count);
  end else begin : g_sat_wide
    assign count_sat = (|count[ADDR_W:6]) ? 6'd63 : count[5:0];
  end

  always_comb begin
    out = 16'h8000;
    if (count != '0) out = {2'b00, count_sat, mem[rd_ptr]};
    out[14] = overflow;
  end
`else
  always_comb begin
    out = 16'h8000;
    if (count != '0) out = {8'h00, mem[rd_ptr]};
  end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus queues expected post-edge outputs, a monitor compares them.
module tb_uart_rx_fifo;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] rx_word = 16'h8000;
  logic        load = 1'b0;
  logic [15:0] out;
  logic        full;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] out;
    logic        full;
    logic        overflow;
  } exp_t;

  exp_t sb [$];

  uart_rx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_word  (rx_word),
    .load     (load),
    .out      (out),
    .full     (full),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] enc(input logic [7:0] head, input int cnt, input logic ovf);
    logic [15:0] w;
    w = (cnt == 0) ? 16'h8000 : {8'h00, head};
`ifdef UART_RX_FIFO_STATUS_EN
    w[14] = ovf;
    if (cnt != 0) w[13:8] = 6'(cnt);
`endif
    return w;
  endfunction

  // Drive one cycle of inputs, then queue what the outputs must be after that edge.
  task automatic cyc(input logic [15:0] rx, input logic ld, input logic rst,
                     input logic [7:0] head, input int cnt, input logic ovf);
    exp_t e;
    rx_word = rx;
    load    = ld;
    reset   = rst;
    @(posedge clk);
    #1;
    e.out      = enc(head, cnt, ovf);
    e.full     = (cnt == 16);
    e.overflow = ovf;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("out", out, e.out);
      check("full", {15'd0, full}, {15'd0, e.full});
      check("overflow", {15'd0, overflow}, {15'd0, e.overflow});
    end
  end

  task automatic fill16();
    for (int i = 1; i <= 16; i++) begin
      cyc({8'h00, 8'(i)}, 1'b0, 1'b0, 8'h01, i, 1'b0);
      cyc(16'h8000, 1'b0, 1'b0, 8'h01, i, 1'b0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset and idle
    cyc(16'h8000, 1'b0, 1'b1, 8'h00, 0, 1'b0);
    cyc(16'h8000, 1'b0, 1'b0, 8'h00, 0, 1'b0);

    // Single byte, then pop
    cyc(16'h0041, 1'b0, 1'b0, 8'h41, 1, 1'b0);
    cyc(16'h8000, 1'b1, 1'b0, 8'h00, 0, 1'b0);

    // Valid held five cycles stores one entry; extra load on empty is harmless
    for (int i = 0; i < 5; i++) cyc(16'h0055, 1'b0, 1'b0, 8'h55, 1, 1'b0);
    cyc(16'h8000, 1'b1, 1'b0, 8'h00, 0, 1'b0);
    cyc(16'h8000, 1'b1, 1'b0, 8'h00, 0, 1'b0);
    cyc(16'h0066, 1'b0, 1'b0, 8'h66, 1, 1'b0);
    cyc(16'h8000, 1'b1, 1'b0, 8'h00, 0, 1'b0);

    // Fill, overflow, drain in order
    fill16();
    cyc(16'h0011, 1'b0, 1'b0, 8'h01, 16, 1'b1);
    cyc(16'h8000, 1'b0, 1'b0, 8'h01, 16, 1'b1);
    for (int k = 1; k <= 16; k++) cyc(16'h8000, 1'b1, 1'b0, 8'(k + 1), 16 - k, 1'b1);
    cyc(16'h8000, 1'b0, 1'b0, 8'h00, 0, 1'b1);

    // Reset clears overflow; push and load together while empty stores the byte
    cyc(16'h8000, 1'b0, 1'b1, 8'h00, 0, 1'b0);
    cyc(16'h0033, 1'b1, 1'b0, 8'h33, 1, 1'b0);
    cyc(16'h8000, 1'b1, 1'b0, 8'h00, 0, 1'b0);

    // Full FIFO with simultaneous push and pop
    fill16();
    cyc(16'h0022, 1'b1, 1'b0, 8'h02, 16, 1'b0);
    cyc(16'h8000, 1'b0, 1'b0, 8'h02, 16, 1'b0);
    for (int k = 1; k <= 16; k++)
      cyc(16'h8000, 1'b1, 1'b0, (k < 15) ? 8'(k + 2) : 8'h22, 16 - k, 1'b0);

    // Reset mid-stream discards queued bytes
    cyc(16'h00A1, 1'b0, 1'b0, 8'hA1, 1, 1'b0);
    cyc(16'h8000, 1'b0, 1'b0, 8'hA1, 1, 1'b0);
    cyc(16'h00A2, 1'b0, 1'b0, 8'hA1, 2, 1'b0);
    cyc(16'h8000, 1'b0, 1'b0, 8'hA1, 2, 1'b0);
    cyc(16'h00A3, 1'b0, 1'b0, 8'hA1, 3, 1'b0);
    cyc(16'h8000, 1'b0, 1'b1, 8'h00, 0, 1'b0);
    cyc(16'h007E, 1'b0, 1'b0, 8'h7E, 1, 1'b0);
    cyc(16'h8000, 1'b1, 1'b0, 8'h00, 0, 1'b0);
    cyc(16'h8000, 1'b0, 1'b0, 8'h00, 0, 1'b0);

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
